// File: rtl/capture_ctrl.sv
// Acquisition sequencer: edge trigger with pre-trigger depth, streaming samples through a
// staging FIFO into an SDRAM ring buffer via a write-only arbiter port.
module capture_ctrl #(
  parameter int unsigned   AN      = 24,
  parameter int unsigned   DN      = 16,
  parameter int unsigned   BURST   = 8,
  parameter logic [AN-1:0] BASE    = 24'he00000,
  parameter int unsigned   DEPTH   = 1024,
  parameter int unsigned   PRE     = 256,
  parameter int unsigned   ADCN    = 10,
  parameter int unsigned   AUTO_TO = 65535
) (
  input  logic            clk_sys_i,
  input  logic            reset_i,
  input  logic            arm_i,
  input  logic            stop_i,
  input  logic [1:0]      mode_i,
  input  logic            edge_i,
  input  logic [ADCN-1:0] level_i,
  input  logic            smp_valid_i,
  input  logic [ADCN-1:0] smp_data_i,
  output logic            req_o,
  output logic [AN-1:0]   req_addr_o,
  output logic [DN-1:0]   req_data_o,
  output logic            req_wr_o,
  input  logic            req_ack_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [AN-1:0]   trig_addr_o,
  output logic            overrun_o
);

  localparam int unsigned FifoDepth = 2 * BURST;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam int unsigned BeatW     = $clog2(BURST + 1);
  localparam int unsigned OffW      = $clog2(DEPTH);
  localparam int unsigned RecW      = $clog2(DEPTH + 1);
  localparam int unsigned AutoW     = $clog2(AUTO_TO + 1);

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StFlush} state_e;

  state_e            state_q, state_d;
  logic [ADCN-1:0]   mem_q [FifoDepth];
  logic [PtrW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OffW-1:0]   off_q, off_d, wptr_q, wptr_d, addr_q, addr_d, trig_q, trig_d;
  logic              burst_q, burst_d, done_q, done_d, overrun_q, overrun_d;
  logic [BeatW-1:0]  beat_q, beat_d, len_q, len_d;
  logic [RecW-1:0]   pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic [AutoW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADCN-1:0]   prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;

  logic capturing, full, accept, pop, edge_hit, auto_hit, start, burst_end;

  always_comb begin
    capturing = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    full      = (cnt_q == CntW'(FifoDepth));
    accept    = capturing && smp_valid_i && !full && !stop_i;
    pop       = burst_q && req_ack_i;
    if (edge_i) begin
      edge_hit = prev_vld_q && (prev_q > level_i) && (smp_data_i <= level_i);
    end else begin
      edge_hit = prev_vld_q && (prev_q < level_i) && (smp_data_i >= level_i);
    end
    auto_hit  = (mode_i == 2'd0) && (wait_cnt_q == AutoW'(AUTO_TO - 1));
    // In FLUSH the tail may be shorter than a burst, so issue whatever is left.
    start     = !burst_q && ((cnt_q >= CntW'(BURST)) ||
                             ((state_q == StFlush) && (cnt_q != '0)));
    burst_end = pop && (beat_q == len_q - BeatW'(1));
  end

  // Sequencer FSM
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    trig_d     = trig_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    wait_cnt_d = wait_cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    unique case (state_q)
      StIdle: begin
        if (arm_i || (done_q && !mode_i[1])) begin
          state_d   = StPre;
          pre_cnt_d = '0;
          if (arm_i) overrun_d = 1'b0;
        end
      end
      StPre: begin
        if (accept) begin
          pre_cnt_d = pre_cnt_q + RecW'(1);
          if (pre_cnt_q == RecW'(PRE - 1)) begin
            state_d    = StWait;
            prev_vld_d = 1'b0;
            wait_cnt_d = '0;
          end
        end
      end
      StWait: begin
        if (accept) begin
          prev_d     = smp_data_i;
          prev_vld_d = 1'b1;
          wait_cnt_d = wait_cnt_q + AutoW'(1);
          if (edge_hit || auto_hit) begin
            trig_d     = off_q;
            post_cnt_d = RecW'(1);
            state_d    = StPost;
          end
        end
      end
      StPost: begin
        if (accept) begin
          post_cnt_d = post_cnt_q + RecW'(1);
          if (post_cnt_q == RecW'(DEPTH - PRE - 1)) state_d = StFlush;
        end
      end
      StFlush: begin
        if ((pop && (cnt_q == CntW'(1))) || ((cnt_q == '0) && !burst_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (capturing && smp_valid_i && full && !stop_i) overrun_d = 1'b1;
    if (stop_i) begin
      state_d   = StIdle;
      done_d    = 1'b0;
      overrun_d = overrun_q;
    end
  end

  // FIFO and write-burst datapath; wptr always tracks the ring offset of the FIFO head.
  always_comb begin
    burst_d = burst_q;
    beat_d  = beat_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wptr_d  = wptr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    off_d   = off_q;
    if (burst_q) begin
      if (pop) begin
        beat_d = beat_q + BeatW'(1);
        wptr_d = wptr_q + OffW'(1);
        rd_d   = rd_q + PtrW'(1);
        if (burst_end) begin
          burst_d = 1'b0;
          beat_d  = '0;
        end
      end
    end else if (start) begin
      burst_d = 1'b1;
      beat_d  = '0;
      addr_d  = wptr_q;
      len_d   = (cnt_q >= CntW'(BURST)) ? BeatW'(BURST) : BeatW'(cnt_q);
    end
    if (accept) begin
      wr_d  = wr_q + PtrW'(1);
      off_d = off_q + OffW'(1);
    end
    cnt_d = cnt_q + CntW'(accept) - CntW'(pop);
    if (stop_i) begin
      burst_d = 1'b0;
      beat_d  = '0;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      wptr_d  = off_q;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (accept) mem_q[wr_q] <= smp_data_i;
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      off_q      <= '0;
      wptr_q     <= '0;
      addr_q     <= '0;
      trig_q     <= '0;
      burst_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      beat_q     <= '0;
      len_q      <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      wait_cnt_q <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      wptr_q     <= wptr_d;
      addr_q     <= addr_d;
      trig_q     <= trig_d;
      burst_q    <= burst_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  always_comb begin
    req_o       = burst_q;
    req_wr_o    = burst_q;
    req_addr_o  = BASE + AN'(addr_q);
    req_data_o  = DN'(mem_q[rd_q]);
    busy_o      = (state_q != StIdle);
    done_o      = done_q;
    trig_addr_o = AN'(trig_q);
    overrun_o   = overrun_q;
  end

endmodule
